// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pkg: shared constants, sequencer state type and the combinational
// decoders (main_decoder / alu_decoder) used by ctrl_pipe.
//
// Contents:
//    - op_code / funct / rt constants and the VALID_OPS list
//    - control bundle bit positions (bundle bit 0 is the MSB, [0:CTRL_W-1])
//    - ALU control codes
//    - MULT/DIV sequencer state encoding
//    - default CTRL_W / ALU_W
package ctrl_pkg;

   localparam int unsigned CTRL_W_DEF = 12;
   localparam int unsigned ALU_W_DEF  = 5;

   // Primary op_code values
   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_REGIMM  = 6'b000001;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_BNE     = 6'b000101;
   localparam logic [5:0] OP_BLEZ    = 6'b000110;
   localparam logic [5:0] OP_BGTZ    = 6'b000111;
   localparam logic [5:0] OP_ADDI    = 6'b001000;
   localparam logic [5:0] OP_ADDIU   = 6'b001001;
   localparam logic [5:0] OP_SLTI    = 6'b001010;
   localparam logic [5:0] OP_SLTIU   = 6'b001011;
   localparam logic [5:0] OP_ANDI    = 6'b001100;
   localparam logic [5:0] OP_ORI     = 6'b001101;
   localparam logic [5:0] OP_XORI    = 6'b001110;
   localparam logic [5:0] OP_LUI     = 6'b001111;
   localparam logic [5:0] OP_LW      = 6'b100011;
   localparam logic [5:0] OP_SW      = 6'b101011;

   localparam int unsigned N_VALID_OPS = 18;
   localparam logic [5:0] VALID_OPS [N_VALID_OPS] = '{
      OP_SPECIAL, OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
      OP_LW, OP_SW};

   // SPECIAL funct values
   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_SRL   = 6'b000010;
   localparam logic [5:0] FN_SRA   = 6'b000011;
   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_DIVU  = 6'b011011;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_XOR   = 6'b100110;
   localparam logic [5:0] FN_NOR   = 6'b100111;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_SLTU  = 6'b101011;

   // REGIMM rt values that also write the link register
   localparam logic [4:0] RT_BLTZAL = 5'b10000;
   localparam logic [4:0] RT_BGEZAL = 5'b10001;

   // Control bundle bit positions
   localparam int unsigned C_REG_WRITE  = 0;
   localparam int unsigned C_REG_DST    = 1;
   localparam int unsigned C_ALU_SRC    = 2;
   localparam int unsigned C_BRANCH     = 3;
   localparam int unsigned C_MEM_READ   = 4;
   localparam int unsigned C_MEM_WRITE  = 5;
   localparam int unsigned C_MEM_TO_REG = 6;
   localparam int unsigned C_JUMP       = 7;
   localparam int unsigned C_SIGN_EXT   = 8;
   localparam int unsigned C_HILO_WRITE = 9;
   localparam int unsigned C_LINK       = 10;
   localparam int unsigned C_JR         = 11;

   typedef logic [0:CTRL_W_DEF-1] ctrl_t;

   typedef enum logic [ALU_W_DEF-1:0] {
      ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT,
      ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_MULT, ALU_MULTU,
      ALU_DIV, ALU_DIVU
   } alu_op_e;

   typedef enum logic {SEQ_IDLE, SEQ_BUSY} seq_state_e;

   function automatic logic is_valid_op(input logic [5:0] op);
      for (int unsigned i = 0; i < N_VALID_OPS; i++)
         if (VALID_OPS[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic is_md_op(input logic [5:0] op, input logic [5:0] funct);
      return (op == OP_SPECIAL) && (funct inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
   endfunction

   function automatic ctrl_t main_decoder(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [5:0] funct);
      ctrl_t c;
      c = '0;
      case (op)
         OP_SPECIAL: begin
            if (is_md_op(op, funct)) c[C_HILO_WRITE] = 1'b1;
            else if (funct == FN_JR) begin
               c[C_JUMP] = 1'b1;
               c[C_JR]   = 1'b1;
            end else begin
               c[C_REG_WRITE] = 1'b1;
               c[C_REG_DST]   = 1'b1;
            end
         end
         OP_REGIMM: begin
            c[C_BRANCH]   = 1'b1;
            c[C_SIGN_EXT] = 1'b1;
            if (rt inside {RT_BLTZAL, RT_BGEZAL}) begin
               c[C_LINK]      = 1'b1;
               c[C_REG_WRITE] = 1'b1;
            end
         end
         OP_J:   c[C_JUMP] = 1'b1;
         OP_JAL: begin
            c[C_JUMP]      = 1'b1;
            c[C_LINK]      = 1'b1;
            c[C_REG_WRITE] = 1'b1;
         end
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
            c[C_BRANCH]   = 1'b1;
            c[C_SIGN_EXT] = 1'b1;
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
            c[C_REG_WRITE] = 1'b1;
            c[C_ALU_SRC]   = 1'b1;
            c[C_SIGN_EXT]  = 1'b1;
         end
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            c[C_REG_WRITE] = 1'b1;
            c[C_ALU_SRC]   = 1'b1;
         end
         OP_LW: begin
            c[C_REG_WRITE]  = 1'b1;
            c[C_ALU_SRC]    = 1'b1;
            c[C_MEM_READ]   = 1'b1;
            c[C_MEM_TO_REG] = 1'b1;
            c[C_SIGN_EXT]   = 1'b1;
         end
         OP_SW: begin
            c[C_ALU_SRC]   = 1'b1;
            c[C_MEM_WRITE] = 1'b1;
            c[C_SIGN_EXT]  = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

   function automatic logic [ALU_W_DEF-1:0] alu_decoder(input logic [5:0] op,
                                                        input logic [5:0] funct);
      alu_op_e a;
      a = ALU_NOP;
      case (op)
         OP_SPECIAL: begin
            case (funct)
               FN_ADD, FN_ADDU: a = ALU_ADD;
               FN_SUB, FN_SUBU: a = ALU_SUB;
               FN_AND:          a = ALU_AND;
               FN_OR:           a = ALU_OR;
               FN_XOR:          a = ALU_XOR;
               FN_NOR:          a = ALU_NOR;
               FN_SLT:          a = ALU_SLT;
               FN_SLTU:         a = ALU_SLTU;
               FN_SLL:          a = ALU_SLL;
               FN_SRL:          a = ALU_SRL;
               FN_SRA:          a = ALU_SRA;
               FN_MULT:         a = ALU_MULT;
               FN_MULTU:        a = ALU_MULTU;
               FN_DIV:          a = ALU_DIV;
               FN_DIVU:         a = ALU_DIVU;
               default:         a = ALU_NOP;
            endcase
         end
         OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: a = ALU_SUB;
         OP_ADDI, OP_ADDIU, OP_LW, OP_SW:             a = ALU_ADD;
         OP_SLTI:  a = ALU_SLT;
         OP_SLTIU: a = ALU_SLTU;
         OP_ANDI:  a = ALU_AND;
         OP_ORI:   a = ALU_OR;
         OP_XORI:  a = ALU_XOR;
         OP_LUI:   a = ALU_LUI;
         default:  a = ALU_NOP;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/ctrl_pipe_md_seq.sv
// md_seq: IDLE/BUSY sequencer tracking EX occupancy of MULT/DIV.
//
// Ports:
//    clk, rst   clock, synchronous active-high reset
//    start      a MULT/DIV is loading into EX on this edge
//    is_div     selects DIV_CYCLES (1) or MUL_CYCLES (0) for start
//    flush      abort any running sequence (no md_done)
//    md_stall   high while the unit still needs more EX cycles
//    md_done    one-cycle pulse in the final EX cycle of the operation
module md_seq
   import ctrl_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = 4,
   parameter int unsigned DIV_CYCLES = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic is_div,
   input  logic flush,
   output logic md_stall,
   output logic md_done
);

   seq_state_e state, state_nxt;
   logic [5:0] cnt, cnt_nxt;

   // Outputs kept outside the next-state block: start is derived from
   // md_stall upstream, so sharing one process would form a false loop.
   assign md_stall = (state == SEQ_BUSY) && (cnt != '0);
   assign md_done  = (state == SEQ_BUSY) && (cnt == '0) && !flush && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SEQ_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (flush) begin
         state_nxt = SEQ_IDLE;
         cnt_nxt   = '0;
      end else if (start) begin
         // cnt holds remaining stall cycles: N-1
         state_nxt = SEQ_BUSY;
         cnt_nxt   = is_div ? 6'(DIV_CYCLES - 1) : 6'(MUL_CYCLES - 1);
      end else if (state == SEQ_BUSY) begin
         if (cnt != '0) cnt_nxt   = cnt - 6'd1;
         else           state_nxt = SEQ_IDLE;
      end
   end

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined instruction controller. Decodes ID fields, registers
// the control bundle into EX with flush/stall/valid handling, and runs the
// MULT/DIV occupancy sequencer.
//
// Optional macro CTRL_PIPE_RI_EN: flag op_codes outside VALID_OPS as
// reserved instructions (ex_ri=1, zeroed bundle, no sequencer start).
//
// Ports:
//    clk, rst          clock, synchronous active-high reset
//    id_valid          ID-stage instruction valid
//    op_code, rt, funct instruction fields [31:26], [20:16], [5:0]
//    stall_i           external hold of the ID/EX control register
//    flush_i           bubble into EX, abort MULT/DIV
//    ex_valid, ex_main_control, ex_alu_control, ex_ri   registered EX controls
//    md_stall          combinational stall request while MULT/DIV busy
//    md_done           MULT/DIV completion pulse
module ctrl_pipe
   import ctrl_pkg::*;
#(
   parameter int unsigned CTRL_W     = CTRL_W_DEF,
   parameter int unsigned ALU_W      = ALU_W_DEF,
   parameter int unsigned MUL_CYCLES = 4,
   parameter int unsigned DIV_CYCLES = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [5:0]        op_code,
   input  logic [4:0]        rt,
   input  logic [5:0]        funct,
   input  logic              stall_i,
   input  logic              flush_i,
   output logic              ex_valid,
   output logic [0:CTRL_W-1] ex_main_control,
   output logic [ALU_W-1:0]  ex_alu_control,
   output logic              ex_ri,
   output logic              md_stall,
   output logic              md_done
);

   logic [0:CTRL_W-1] dec_main;
   logic [ALU_W-1:0]  dec_alu;
   logic              ri, hold, load, start;

   assign dec_main = CTRL_W'(main_decoder(op_code, rt, funct));
   assign dec_alu  = ALU_W'(alu_decoder(op_code, funct));

`ifdef CTRL_PIPE_RI_EN
   assign ri = ~is_valid_op(op_code);
`else
   assign ri = 1'b0;
`endif

   assign hold  = stall_i | md_stall;
   assign load  = ~flush_i & ~hold;
   assign start = load & id_valid & ~ri & is_md_op(op_code, funct);

   md_seq #(
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_md_seq (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .is_div   (funct[1]),
      .flush    (flush_i),
      .md_stall (md_stall),
      .md_done  (md_done)
   );

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         ex_valid        <= 1'b0;
         ex_main_control <= '0;
         ex_alu_control  <= '0;
         ex_ri           <= 1'b0;
      end else if (load) begin
         ex_valid        <= id_valid;
         ex_main_control <= (id_valid && !ri) ? dec_main : '0;
         ex_alu_control  <= (id_valid && !ri) ? dec_alu  : '0;
         ex_ri           <= id_valid & ri;
      end
   end

endmodule
